mux2_rr_arbiter: RTL and testbench

Two-requester round-robin arbiter that owns the select line of the 2x1 multiplexer and shares one downstream data path between requester A and requester B. It registers grants, holds a grant for the owner's whole transfer, and alternates priority on contention. The block sits between two producers, such as the ALU result path and the memory read path, and a single shared consumer bus.

---
 rtl/mux2_arb_pkg.sv | 15 +
 rtl/two_one_multi.sv | 11 +
 rtl/mux2_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int ARB_CNT_W = 8;

endpackage

// File: rtl/two_one_multi.sv
// 1-bit 2:1 multiplexer: C follows A when S=0 and B when S=1.
module two_one_multi (
  input  logic S,
  input  logic A,
  input  logic B,
  output logic C
);

  assign C = S ? B : A;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter owning the select of a DATA_W-wide 2:1 mux.
// Optional tenure limit (preemption after MAX_BEATS cycles) under MUX2_ARB_TIMEOUT_EN.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output arb_state_t        dbg_state
);

  // Handshake: req_x stays high for the whole transfer; a beat moves on every
  // cycle where gnt_x and req_x are both high (out_valid); dropping req_x
  // releases the bus, and a later re-assertion is a fresh request.

  if (MAX_BEATS < 1 || MAX_BEATS > 255) begin : g_bad_max_beats
    $error("mux2_rr_arbiter: MAX_BEATS must be in 1..255");
  end

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic       sel_q, sel_d;
  logic       gnt_a_q, gnt_a_d;
  logic       gnt_b_q, gnt_b_d;

`ifdef MUX2_ARB_TIMEOUT_EN
  localparam logic [ARB_CNT_W-1:0] CNT_MAX = ARB_CNT_W'(MAX_BEATS - 1);
  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 at_limit;
  assign at_limit = (cnt_q == CNT_MAX);
`else
  logic at_limit;
  assign at_limit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (req_a && req_b) state_d = (last_q == SEL_B) ? OWN_A : OWN_B;
        else if (req_a)     state_d = OWN_A;
        else if (req_b)     state_d = OWN_B;
      end
      OWN_A: begin
        if (!req_a)                 state_d = req_b ? OWN_B : IDLE;
        else if (req_b && at_limit) state_d = OWN_B;
      end
      OWN_B: begin
        if (!req_b)                 state_d = req_a ? OWN_A : IDLE;
        else if (req_a && at_limit) state_d = OWN_A;
      end
      default: state_d = IDLE;
    endcase

    // Only a grant transition moves the pointer and the select; IDLE holds them.
    if (state_d != state_q && state_d == OWN_A) begin
      last_d = SEL_A;
      sel_d  = SEL_A;
    end else if (state_d != state_q && state_d == OWN_B) begin
      last_d = SEL_B;
      sel_d  = SEL_B;
    end

    gnt_a_d = (state_d == OWN_A);
    gnt_b_d = (state_d == OWN_B);

`ifdef MUX2_ARB_TIMEOUT_EN
    if (state_d != IDLE && state_d == state_q) cnt_d = at_limit ? cnt_q : cnt_q + 1'b1;
    else                                       cnt_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= SEL_B;
      sel_q   <= SEL_A;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
`ifdef MUX2_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
`ifdef MUX2_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign sel       = sel_q;
  assign dbg_state = state_q;
  assign out_valid = (gnt_a_q & req_a) | (gnt_b_q & req_b);

  for (genvar i = 0; i < DATA_W; i++) begin : g_mux
    two_one_multi u_mux (
      .S(sel_q),
      .A(data_a[i]),
      .B(data_b[i]),
      .C(out_data[i])
    );
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: directed scenarios plus randomized traffic
// checked against an owner/last/tenure reference model.
module tb_mux2_rr_arbiter;

  localparam int DATA_W    = 32;
  localparam int MAX_BEATS = 4;
  localparam int W         = DATA_W + 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_a, req_b;
  logic [DATA_W-1:0] data_a, data_b;
  logic              gnt_a, gnt_b, sel, out_valid;
  logic [DATA_W-1:0] out_data;
  mux2_arb_pkg::arb_state_t dbg_state;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .data_a(data_a),
    .req_b(req_b), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
    .out_valid(out_valid), .out_data(out_data),
    .dbg_state(dbg_state)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: owner (-1 none, 0 A, 1 B), most recent owner, select, tenure
  int m_owner;
  int m_last;
  bit m_sel;
  int m_ten;

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_sel   = 1'b0;
    m_ten   = 0;
  endtask

  task automatic model_step(input bit rst, input bit ra, input bit rb);
    bit r[2];
    int nxt;
    int oth;
    if (rst) begin
      model_reset();
      return;
    end
    r[0] = ra;
    r[1] = rb;
    if (m_owner < 0) begin
      if (ra && rb) nxt = 1 - m_last;
      else if (ra)  nxt = 0;
      else if (rb)  nxt = 1;
      else          nxt = -1;
    end else begin
      oth = 1 - m_owner;
      if (!r[m_owner]) nxt = r[oth] ? oth : -1;
`ifdef MUX2_ARB_TIMEOUT_EN
      else if (r[oth] && m_ten == MAX_BEATS - 1) nxt = oth;
`endif
      else nxt = m_owner;
    end
    if (nxt < 0)              m_ten = 0;
    else if (nxt != m_owner)  m_ten = 0;
    else if (m_ten < MAX_BEATS - 1) m_ten = m_ten + 1;
    if (nxt >= 0 && nxt != m_owner) begin
      m_last = nxt;
      m_sel  = (nxt == 1);
    end
    m_owner = nxt;
  endtask

  // Drive one cycle of inputs, queue the expected outputs, advance the model.
  task automatic cyc(input bit rst, input bit ra, input bit rb,
                     input logic [DATA_W-1:0] da, input logic [DATA_W-1:0] db);
    logic [W-1:0] e;
    bit ev;
    reset  = rst;
    req_a  = ra;
    req_b  = rb;
    data_a = da;
    data_b = db;
    ev = (m_owner == 0 && ra) || (m_owner == 1 && rb);
    e = {(m_owner == 0), (m_owner == 1), m_sel, ev, (m_sel ? db : da)};
    exp_q.push_back(e);
    model_step(rst, ra, rb);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_n(input int n, input bit rst, input bit ra, input bit rb);
    for (int i = 0; i < n; i++) cyc(rst, ra, rb, $urandom, $urandom);
  endtask

  // Monitor: compare presented outputs against the queue away from the active edge
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {gnt_a, gnt_b, sel, out_valid, out_data};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs cycle %0d: got gnt_a=%b gnt_b=%b sel=%b valid=%b data=%h, expected gnt_a=%b gnt_b=%b sel=%b valid=%b data=%h",
                 cycle, act_v[W-1], act_v[W-2], act_v[W-3], act_v[W-4], act_v[DATA_W-1:0],
                 exp_v[W-1], exp_v[W-2], exp_v[W-3], exp_v[W-4], exp_v[DATA_W-1:0]);
      end
      if (gnt_a === 1'b1 && gnt_b === 1'b1) begin
        errors++;
        $display("FAIL grant_exclusive cycle %0d: got both grants high, expected at most one", cycle);
      end
    end
    cycle++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ra, rb, rst;
    reset  = 1'b1;
    req_a  = 1'b0;
    req_b  = 1'b0;
    data_a = '0;
    data_b = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset held with both requests high, then A wins the first contention
    cyc_n(2, 1'b1, 1'b1, 1'b1);
    cyc_n(3, 1'b0, 1'b1, 1'b1);
    cyc_n(2, 1'b0, 1'b0, 1'b1);
    cyc_n(2, 1'b0, 1'b0, 1'b0);

    // Single requester B with a fixed data word
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, $urandom, 32'hDEAD_BEEF);
    cyc_n(2, 1'b0, 1'b0, 1'b0);

    // Contention after B owned last: A first, A releases, B follows without a bubble
    cyc_n(3, 1'b0, 1'b1, 1'b1);
    cyc_n(2, 1'b0, 1'b0, 1'b1);
    // Back-to-back handoff: B drops as A rises
    cyc_n(3, 1'b0, 1'b1, 1'b0);
    cyc_n(1, 1'b0, 1'b0, 1'b0);

    // Long contention: preemption when the tenure limit is built in, starvation otherwise
    cyc_n(1, 1'b0, 1'b1, 1'b0);
    cyc_n(10, 1'b0, 1'b1, 1'b1);
    cyc_n(8, 1'b0, 1'b1, 1'b0);
    cyc_n(2, 1'b0, 1'b0, 1'b0);

    // Reset while B owns the bus
    cyc_n(3, 1'b0, 1'b0, 1'b1);
    cyc_n(1, 1'b1, 1'b0, 1'b1);
    cyc_n(2, 1'b0, 1'b0, 1'b1);
    cyc_n(1, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with sticky requests and occasional resets
    ra = 1'b0;
    rb = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) ra = ~ra;
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      rst = ($urandom_range(0, 63) == 0);
      cyc(rst, ra, rb, $urandom, $urandom);
    end
    cyc_n(2, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
